count_scheduler: RTL and testbench

- Round-robin scheduler that shares one N-bit up-counter between M requesters.
- Each requester asks for a timed interval of (len+1) clock cycles.
- The block arbitrates, latches the winner's length, runs the shared counter, then pulses a per-requester done.
- Sits between client logic and the team's counter datapath, as the sequencing/sharing layer for counter resources.

---
 rtl/count_sched_pkg.sv | 20 ++
 rtl/count_scheduler_rr_arbiter.sv | 29 ++
 rtl/count_scheduler.sv | 147 ++++++++++++++
 tb/tb_count_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and reset values for the count_scheduler slice.
// Optional feature macro used by the slice: COUNT_SCHED_ABORT_EN.
package count_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
  localparam logic   RST_ABORT = 1'b0;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/count_scheduler_rr_arbiter.sv
// Combinational rotate-priority search: first set req bit above 'last', wrapping.
module rr_arbiter #(
  parameter int M  = 3,
  parameter int LW = count_sched_pkg::idx_width(M)
) (
  input  logic [M-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [M-1:0]  grant_next,
  output logic          any
);

  localparam int unsigned MU = M;

  logic [LW-1:0] pos;

  always_comb begin
    grant_next = '0;
    any        = 1'b0;
    pos        = '0;
    for (int unsigned k = 1; k <= MU; k++) begin
      pos = LW'((32'(last) + k) % MU);
      if (!any && req[pos]) begin
        grant_next[pos] = 1'b1;
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin sharing of one N-bit interval counter between M requesters.
// Define COUNT_SCHED_ABORT_EN to add the abort output and early-release on req drop.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] len,
  output logic [M-1:0]   gnt,
  output logic [M-1:0]   done,
  output logic           busy,
  output logic [N-1:0]   count
`ifdef COUNT_SCHED_ABORT_EN
  ,
  output logic           abort
`endif
);

  localparam int LW = idx_width(M);
  localparam logic [LW-1:0] RST_LAST = LW'(M - 1);

  state_t        state_q, state_d;
  logic [M-1:0]  gnt_q, gnt_d;
  logic [M-1:0]  done_q, done_d;
  logic [N-1:0]  count_q, count_d;
  logic [N-1:0]  len_q, len_d;
  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] win_q, win_d;
`ifdef COUNT_SCHED_ABORT_EN
  logic          abort_q, abort_d;
`endif

  logic [M-1:0]  arb_gnt;
  logic          arb_any;
  logic [LW-1:0] arb_idx;
  logic [N-1:0]  arb_len;

  rr_arbiter #(.M(M), .LW(LW)) u_arb (
    .req        (req),
    .last       (last_q),
    .grant_next (arb_gnt),
    .any        (arb_any)
  );

  always_comb begin
    arb_idx = '0;
    arb_len = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (arb_gnt[i]) begin
        arb_idx = LW'(i);
        arb_len = len[i*N +: N];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    count_d = count_q;
    len_d   = len_q;
    last_d  = last_q;
    win_d   = win_q;
`ifdef COUNT_SCHED_ABORT_EN
    abort_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d   = '0;
        count_d = '0;
        if (arb_any) begin
          state_d = ST_COUNT;
          gnt_d   = arb_gnt;
          len_d   = arb_len;
          win_d   = arb_idx;
        end
      end
      ST_COUNT: begin
`ifdef COUNT_SCHED_ABORT_EN
        // A dropped request ends the interval early; count keeps its last value.
        if (!req[win_q]) begin
          state_d = ST_DONE;
          gnt_d   = '0;
          abort_d = 1'b1;
          last_d  = win_q;
        end else
`endif
        if (count_q == len_q) begin
          state_d = ST_DONE;
          gnt_d   = '0;
          done_d  = gnt_q;
          last_d  = win_q;
        end else begin
          count_d = count_q + N'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      gnt_q   <= '0;
      done_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      last_q  <= RST_LAST;
      win_q   <= '0;
`ifdef COUNT_SCHED_ABORT_EN
      abort_q <= RST_ABORT;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      count_q <= count_d;
      len_q   <= len_d;
      last_q  <= last_d;
      win_q   <= win_d;
`ifdef COUNT_SCHED_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q != ST_IDLE) ? 1'b1 : RST_BUSY;
`ifdef COUNT_SCHED_ABORT_EN
  assign abort = abort_q;
`endif

endmodule

// File: tb/tb_count_scheduler.sv
// Directed scoreboard bench for count_scheduler (N=4, M=3).
module tb_count_scheduler;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] len;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic [3:0]  count;
  logic        abort_w;

  count_scheduler #(.N(4), .M(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
`ifdef COUNT_SCHED_ABORT_EN
    ,
    .abort (abort_w)
`endif
  );

`ifndef COUNT_SCHED_ABORT_EN
  assign abort_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] g;
    logic [2:0] d;
    logic [3:0] c;
    logic       b;
    logic       a;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic push(input string tag, input logic [2:0] g, input logic [2:0] d,
                      input logic [3:0] c, input logic b, input logic a);
    exp_t e;
    e.tag = tag; e.g = g; e.d = d; e.c = c; e.b = b; e.a = a;
    q.push_back(e);
  endtask

  task automatic chk_now();
    exp_t       e;
    logic [11:0] obs, expv;
    n_total++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed no expectation, expected one queued");
    end else begin
      e    = q.pop_front();
      obs  = {gnt, done, count, busy, abort_w};
      expv = {e.g, e.d, e.c, e.b, e.a};
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed gnt=%b done=%b count=%0d busy=%b abort=%b, expected gnt=%b done=%b count=%0d busy=%b abort=%b",
                  e.tag, gnt, done, count, busy, abort_w, e.g, e.d, e.c, e.b, e.a);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] g, input logic [2:0] d,
                     input logic [3:0] c, input logic b, input logic a);
    push(tag, g, d, c, b, a);
    @(posedge clk);
    #2;
    chk_now();
  endtask

  task automatic set_len(input int i, input logic [3:0] v);
    len[i*4 +: 4] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req = '0;
    len = '0;

    // Reset pulsed mid-cycle, then idle
    #3 rst = 1'b1;
    #1 push("reset_async", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);
    chk_now();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc("reset_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);

    // Single request, len=3: four COUNT cycles then one done pulse
    req = 3'b010;
    set_len(1, 4'd3);
    for (int c = 0; c < 4; c++) cyc("single_count", 3'b010, 3'b000, 4'(c), 1'b1, 1'b0);
    cyc("single_done", 3'b000, 3'b010, 4'd3, 1'b1, 1'b0);
    req = '0;
    cyc("single_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);
    cyc("single_idle2", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);

    // Fresh reset so requester 0 has top priority for the rotation check
    #1 rst = 1'b1;
    #1 push("reset_again", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);
    chk_now();
    @(posedge clk);
    #1 rst = 1'b0;
    len = '0;
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      logic [2:0] oh;
      oh = 3'b001 << (r % 3);
      cyc("rr_grant", oh, 3'b000, 4'd0, 1'b1, 1'b0);
      cyc("rr_done", 3'b000, oh, 4'd0, 1'b1, 1'b0);
      if (r < 3) cyc("rr_gap", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);
    end
    req = '0;
    cyc("rr_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);

    // Full-range count with len changed mid-interval
    req = 3'b001;
    set_len(0, 4'd15);
    for (int c = 0; c < 16; c++) begin
      cyc("full_count", 3'b001, 3'b000, 4'(c), 1'b1, 1'b0);
      if (c == 5) set_len(0, 4'd2);
    end
    cyc("full_done", 3'b000, 3'b001, 4'd15, 1'b1, 1'b0);
    req = '0;
    cyc("full_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);

    // Zero-length interval
    req = 3'b100;
    set_len(2, 4'd0);
    cyc("len0_grant", 3'b100, 3'b000, 4'd0, 1'b1, 1'b0);
    cyc("len0_done", 3'b000, 3'b100, 4'd0, 1'b1, 1'b0);
    req = '0;
    cyc("len0_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of a len=7 interval
    req = 3'b001;
    set_len(0, 4'd7);
    for (int c = 0; c < 3; c++) cyc("midrst_count", 3'b001, 3'b000, 4'(c), 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 push("midrst_async", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);
    chk_now();
    cyc("midrst_held", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);
    cyc("midrst_held2", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    len = '0;
    req = 3'b111;
    cyc("midrst_first_winner", 3'b001, 3'b000, 4'd0, 1'b1, 1'b0);
    cyc("midrst_done", 3'b000, 3'b001, 4'd0, 1'b1, 1'b0);
    req = '0;
    cyc("midrst_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);

    // Request dropped at count=1 of a len=5 interval
    req = 3'b010;
    set_len(1, 4'd5);
    cyc("drop_count0", 3'b010, 3'b000, 4'd0, 1'b1, 1'b0);
    cyc("drop_count1", 3'b010, 3'b000, 4'd1, 1'b1, 1'b0);
    req = '0;
`ifdef COUNT_SCHED_ABORT_EN
    cyc("drop_abort", 3'b000, 3'b000, 4'd1, 1'b1, 1'b1);
`else
    for (int c = 2; c < 6; c++) cyc("drop_count", 3'b010, 3'b000, 4'(c), 1'b1, 1'b0);
    cyc("drop_done", 3'b000, 3'b010, 4'd5, 1'b1, 1'b0);
`endif
    cyc("drop_idle", 3'b000, 3'b000, 4'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
